// File: rtl/multi_arbiter_if.sv
// multi_arbiter_if: request/grant bundle between N masters and the arbiter.
// master drives requests and mode; slave is the arbiter side.
interface multi_arbiter_if #(
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   REQUEST;
  logic           MODE;
  logic [N-1:0]   GRANT_O;
  logic           GRANT_VALID;
  logic [IDW-1:0] GRANT_ID;

  modport master (
    output REQUEST,
    output MODE,
    input  GRANT_O,
    input  GRANT_VALID,
    input  GRANT_ID
  );

  modport slave (
    input  REQUEST,
    input  MODE,
    output GRANT_O,
    output GRANT_VALID,
    output GRANT_ID
  );
endinterface

// File: rtl/multi_arbiter.sv
// multi_arbiter: N-channel registered one-hot arbiter, fixed-priority or
// round-robin, with a bounded tenure so no owner holds the grant forever.
module multi_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input logic             clk,
  input logic             rst,
  multi_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_grant;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [7:0]     r_hold;
  logic [IDW-1:0] r_ptr;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_next_ptr;
  logic           w_keep;
  logic [N-1:0]   w_one;

  assign w_one = {{(N-1){1'b0}}, 1'b1};

  // Winner search: lowest index in fixed mode, first at/after r_ptr in rr.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N; i++) begin
      j = bus.MODE ? (int'(r_ptr) + i) % N : i;
      if (!w_found && bus.REQUEST[j]) begin
        w_found = 1'b1;
        w_win   = IDW'(j);
      end
    end
  end

  assign w_next_ptr = (w_win == IDW'(N - 1)) ? '0 : w_win + 1'b1;

  // r_id doubles as the owner index while BUSY.
  assign w_keep = (r_state == BUSY) && bus.REQUEST[r_id] &&
                  (r_hold < 8'(HOLD_MAX));

  // Tenure/arbitration FSM; every grant output is registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_hold  <= '0;
      r_ptr   <= '0;
    end else if (w_keep) begin
      r_hold <= r_hold + 8'd1;
    end else if (w_found) begin
      r_state <= BUSY;
      r_grant <= w_one << w_win;
      r_valid <= 1'b1;
      r_id    <= w_win;
      r_hold  <= 8'd1;
      r_ptr   <= w_next_ptr;
    end else begin
      r_state <= IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_hold  <= '0;
    end
  end

  assign bus.GRANT_O     = r_grant;
  assign bus.GRANT_VALID = r_valid;
  assign bus.GRANT_ID    = r_id;
endmodule

// File: tb/tb_multi_arbiter.sv
// tb_multi_arbiter: directed vectors against three arbiter configurations
// (N=4/HOLD=3, N=4/HOLD=1, N=16/HOLD=2).
module tb_multi_arbiter;
  logic clk;
  logic rst_a, rst_b, rst_c;
  int   n_chk;
  int   n_fail;

  multi_arbiter_if #(.N(4))  if_a ();
  multi_arbiter_if #(.N(4))  if_b ();
  multi_arbiter_if #(.N(16)) if_c ();

  multi_arbiter #(.N(4), .HOLD_MAX(3)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a.slave)
  );

  multi_arbiter #(.N(4), .HOLD_MAX(1)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b.slave)
  );

  multi_arbiter #(.N(16), .HOLD_MAX(2)) u_c (
    .clk (clk),
    .rst (rst_c),
    .bus (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic [3:0] g,
                       input int id);
    chk({tag, ".grant"}, 32'(if_a.GRANT_O), 32'(g));
    chk({tag, ".valid"}, 32'(if_a.GRANT_VALID), 32'(g != 4'b0));
    chk({tag, ".id"}, 32'(if_a.GRANT_ID), 32'(id));
  endtask

  task automatic exp_b(input string tag, input logic [3:0] g,
                       input int id);
    chk({tag, ".grant"}, 32'(if_b.GRANT_O), 32'(g));
    chk({tag, ".id"}, 32'(if_b.GRANT_ID), 32'(id));
  endtask

  task automatic exp_c(input string tag, input logic [15:0] g,
                       input int id);
    chk({tag, ".grant"}, 32'(if_c.GRANT_O), 32'(g));
    chk({tag, ".id"}, 32'(if_c.GRANT_ID), 32'(id));
    chk({tag, ".onehot"}, 32'($onehot(if_c.GRANT_O)), 32'(1));
  endtask

  logic [3:0] rr_g [13];
  int         rr_id[13];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.REQUEST = 4'b1111; if_a.MODE = 1'b1;
    if_b.REQUEST = 4'b0000; if_b.MODE = 1'b1;
    if_c.REQUEST = 16'h0;   if_c.MODE = 1'b1;

    // reset held two cycles with all requests up
    tick(); exp_a("rst0", 4'b0000, 0);
    tick(); exp_a("rst1", 4'b0000, 0);

    // round-robin, HOLD_MAX=3, all requesting
    for (int i = 0; i < 13; i++) begin
      rr_g[i]  = 4'b0001 << ((i / 3) % 4);
      rr_id[i] = (i / 3) % 4;
    end
    rst_a = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick(); exp_a($sformatf("rr%0d", i), rr_g[i], rr_id[i]);
    end

    // mid-tenure reset, then restart from channel 0
    tick(); exp_a("pre_rst", 4'b0001, 0);
    rst_a = 1'b1;
    tick(); exp_a("mid_rst", 4'b0000, 0);
    rst_a = 1'b0;
    tick(); exp_a("restart", 4'b0001, 0);

    // fixed priority: owner 0 dropped, only 2 and 3 requesting
    if_a.MODE = 1'b0; if_a.REQUEST = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      tick(); exp_a($sformatf("fp%0d", i), 4'b0100, 2);
    end
    // higher-priority arrival must wait for expiry
    if_a.REQUEST = 4'b1101;
    tick(); exp_a("fp_hold0", 4'b0100, 2);
    tick(); exp_a("fp_hold1", 4'b0100, 2);
    tick(); exp_a("fp_expire", 4'b0001, 0);

    // release without bubble
    rst_a = 1'b1; if_a.MODE = 1'b1; if_a.REQUEST = 4'b0011;
    tick();
    rst_a = 1'b0;
    tick(); exp_a("rel0", 4'b0001, 0);
    if_a.REQUEST = 4'b0010;
    tick(); exp_a("rel1", 4'b0010, 1);
    if_a.REQUEST = 4'b0000;
    tick(); exp_a("rel_none", 4'b0000, 0);

    // HOLD_MAX=1 strict rotation between channels 1 and 3
    if_b.REQUEST = 4'b1010;
    rst_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_b($sformatf("rot%0d", i),
            (i % 2 == 0) ? 4'b0010 : 4'b1000,
            (i % 2 == 0) ? 1 : 3);
    end

    // N=16: park rr_ptr at 15 via a grant to 14, then wrap 15 -> 0
    rst_c = 1'b0;
    if_c.REQUEST = 16'h4000;
    tick(); exp_c("w14", 16'h4000, 14);
    if_c.REQUEST = 16'h8001;
    tick(); exp_c("w15a", 16'h8000, 15);
    tick(); exp_c("w15b", 16'h8000, 15);
    tick(); exp_c("w0a", 16'h0001, 0);
    tick(); exp_c("w0b", 16'h0001, 0);
    tick(); exp_c("w15c", 16'h8000, 15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_arbiter.md
# multi_arbiter

Parametrised N-channel arbiter and successor to the fixed 4-request arbiter. It registers a one-hot grant to one of N requesters. It supports a runtime-selectable fixed-priority or round-robin mode and a bounded grant hold (tenure), so that no requester keeps the grant forever. It sits between N bus/resource masters and a shared resource. GRANT_O is the resource-select.

## Interface
- N, default 4: number of request channels; legal range 2..16.
- HOLD_MAX, default 8: maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- IDW, default $clog2(N): width of GRANT_ID (derived, not overridden).

- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  reset, synchronous, active-high.
- REQUEST  input  N  request vector; bit i = channel i requesting; level-sensitive.
- MODE  input  1  0 = fixed priority (bit 0 highest); 1 = round-robin.
- GRANT_O  output  N  registered grant, one-hot or all-zero.
- GRANT_VALID  output  1  high iff GRANT_O != 0.
- GRANT_ID  output  IDW  index of the granted channel; 0 when GRANT_VALID = 0.

## Operation
- Internal state: owner index, hold counter (8-bit), round-robin pointer rr_ptr (IDW bits), FSM state IDLE/BUSY.
- Reset (rst = 1 at a rising edge) clears everything:
  - GRANT_O = 0, GRANT_VALID = 0, GRANT_ID = 0
  - rr_ptr = 0, hold counter = 0, state = IDLE
  - rst overrides all other inputs, including mid-tenure.
- **IDLE**:
  - REQUEST == 0 → stay in IDLE, outputs stay zero.
  - Otherwise → arbitrate (below), register the winner, hold counter = 1, go to BUSY.
- **BUSY**, owner k:
  - REQUEST[k] = 1 and hold counter < HOLD_MAX → keep the grant, hold counter += 1.
  - REQUEST[k] = 0, or hold counter == HOLD_MAX → re-arbitrate at the same edge, with no idle bubble.
  - Re-arbitration with a winner → new owner, hold counter = 1, stay in BUSY.
  - Re-arbitration with REQUEST == 0 → outputs clear, go to IDLE.
- **Arbitration**, combinational over the current REQUEST:
  - MODE = 0: the lowest-index asserted bit wins. rr_ptr is still updated.
  - MODE = 1: the first asserted bit at or after rr_ptr wins, searching upward modulo N (wrap from N-1 to 0).
  - On every new grant to channel w, rr_ptr ← (w+1) mod N.
  - If the only requester is the expired owner, it is re-granted with hold counter = 1. This is a new tenure.
- MODE is sampled only at arbitration edges. Changing it mid-tenure does not affect the current owner.
- GRANT_O, GRANT_VALID and GRANT_ID always change together and are mutually consistent.

## Timing
- All outputs are registered; no combinational path from REQUEST to GRANT_O.
- Latency: REQUEST sampled at edge t produces GRANT_O valid from edge t onward (visible after t), i.e. one cycle after the inputs settle.
- Release: owner drops its request before edge t → at edge t the grant moves to the next winner, or to zero.
- Tenure: an uninterrupted owner holds exactly HOLD_MAX cycles. It then re-arbitrates at the next edge.
- HOLD_MAX = 1: in MODE = 1, re-arbitrates every cycle, giving strict per-cycle rotation.
- Simultaneous owner drop and expiry: treated as a single re-arbitration.
- A new request arriving mid-tenure never pre-empts the owner.

## Test plan
- **Reset:** assert rst for 2 cycles with REQUEST = 1111 → GRANT_O = 0000, GRANT_VALID = 0, GRANT_ID = 0 throughout. Then assert rst mid-tenure → GRANT_O = 0000 at that edge; after release, the grant restarts at channel 0 (rr_ptr = 0).
- **Round-robin:** N = 4, HOLD_MAX = 3, MODE = 1, REQUEST held 1111 after reset → GRANT_O = 0001 ×3, then 0010 ×3, 0100 ×3, 1000 ×3, then 0001 (wrap).
- **Fixed priority:** MODE = 0, REQUEST = 1100 → GRANT_O = 0100 continuously, re-granted every 3 cycles. Then change REQUEST to 1101 mid-tenure → 0100 until expiry, then 0001.
- **Release without bubble:** MODE = 1, REQUEST = 0011, owner 0 drops its bit after 1 cycle → GRANT_O goes 0001 → 0010 on the next edge, with no 0000 cycle. Then drop all requests → 0000, GRANT_VALID = 0, GRANT_ID = 0.
- **Single-cycle rotation:** HOLD_MAX = 1, MODE = 1, REQUEST = 1010 → GRANT_O alternates 0010, 1000, 0010, … every cycle. GRANT_ID alternates 1, 3.
- **Width scaling:** N = 16, MODE = 1, REQUEST = 16'h8001, rr_ptr at 15 → grant to bit 15, then wrap to bit 0. Check GRANT_ID = 15, then 0. Check GRANT_O is one-hot on every cycle (assertion).
